fetch_stage: RTL and testbench

Instruction-fetch front end of the 5-stage MIPS pipeline. It owns the PC register and issues single-outstanding requests to instruction memory over a req/ready + rvalid handshake. Returned words are held in a 2-entry buffer tagged with PC+4 and presented as inst_F/NPC_F to the IF/ID register. It honours StallF and decode-stage redirects (branch/jump), discarding in-flight wrong-path fetches.

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_buf.sv | 53 +++++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

   localparam logic [31:0] NOP_INST         = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] npc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch_stage and imem.
interface fetch_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry in-order buffer of fetched {inst, npc}; flush beats push and pop.
module fetch_buf
   import mips_pkg::*;
(
   input  logic         clk,
   input  logic         clr,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t push_data_i,
   output logic [1:0]   count_o,
   output fetch_entry_t head_o
);

   fetch_entry_t e0_q, e0_d, e1_q, e1_d;
   logic [1:0]   count_q, count_d;
   logic         push_ok, pop_ok;

   always_comb begin
      pop_ok  = pop_i && (count_q != 2'd0);
      push_ok = push_i && ((count_q != 2'd2) || pop_ok);
      e0_d    = e0_q;
      e1_d    = e1_q;
      count_d = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         if (pop_ok) e0_d = e1_q;
         if (push_ok) begin
            // New entry lands directly behind whatever survives the pop.
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop_ok)) e0_d = push_data_i;
            else                                                      e1_d = push_data_i;
         end
         count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         e0_q    <= '0;
         e1_q    <= '0;
         count_q <= 2'd0;
      end else begin
         e0_q    <= e0_d;
         e1_q    <= e1_d;
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = e0_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem requests, 2-entry return buffer.
// Optional FETCH_PERF_EN adds perf_fetched / perf_discarded counters.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          StallF,
   input  logic          PCSrcD,
   input  logic [31:0]   PCBranchD,
   fetch_stage_if.master imem,
   output logic [31:0]   inst_F,
   output logic [31:0]   NPC_F,
   output logic          valid_F
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]   perf_fetched,
   output logic [31:0]   perf_discarded
`endif
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d, tag_q, tag_d, addr_q, addr_d;
   logic         req_q, req_d, discard_q, discard_d;
   logic [1:0]   count, count_nxt;
   fetch_entry_t head, push_data;
   logic         push, pop, accept, resp;

   always_comb begin
      accept    = (state_q == REQ) && imem.imem_ready;
      resp      = (state_q == WAIT) && imem.imem_rvalid;
      push      = resp && !discard_q && !PCSrcD;
      pop       = valid_F && !StallF;
      count_nxt = PCSrcD ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
      push_data = '{inst: imem.imem_rdata, npc: tag_q};

      state_d   = state_q;
      pc_d      = PCSrcD ? PCBranchD : pc_q;
      tag_d     = tag_q;
      addr_d    = addr_q;
      req_d     = req_q;
      discard_d = discard_q;

      unique case (state_q)
         IDLE: begin
            if (count_nxt <= 2'd1) begin
               state_d = REQ;
               req_d   = 1'b1;
               addr_d  = pc_d;
            end
         end
         REQ: begin
            if (PCSrcD) discard_d = 1'b1;
            if (accept) begin
               state_d = WAIT;
               req_d   = 1'b0;
               tag_d   = addr_q + 32'd4;
               // A stale request (discard set) was not for pc_q, so pc_q must not advance.
               if (!PCSrcD && !discard_q) pc_d = pc_q + 32'd4;
            end
         end
         WAIT: begin
            if (resp) begin
               discard_d = 1'b0;
               if (count_nxt <= 2'd1) begin
                  state_d = REQ;
                  req_d   = 1'b1;
                  addr_d  = pc_d;
               end else begin
                  state_d = IDLE;
               end
            end else if (PCSrcD) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         tag_q     <= 32'h0;
         addr_q    <= 32'h0;
         req_q     <= 1'b0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         tag_q     <= tag_d;
         addr_q    <= addr_d;
         req_q     <= req_d;
         discard_q <= discard_d;
      end
   end

   fetch_buf u_buf (
      .clk         (clk),
      .clr         (clr),
      .push_i      (push),
      .pop_i       (pop),
      .flush_i     (PCSrcD),
      .push_data_i (push_data),
      .count_o     (count),
      .head_o      (head)
   );

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;
   assign valid_F        = (count != 2'd0);
   assign inst_F         = valid_F ? head.inst : NOP_INST;
   assign NPC_F          = valid_F ? head.npc : 32'h0;

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q, fetched_d, discarded_q, discarded_d;
   logic        dropped;

   always_comb begin
      dropped     = resp && (discard_q || PCSrcD);
      fetched_d   = fetched_q + {31'd0, push};
      discarded_d = discarded_q + {31'd0, dropped} + (PCSrcD ? {30'd0, count} : 32'd0);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         fetched_q   <= 32'h0;
         discarded_q <= 32'h0;
      end else begin
         fetched_q   <= fetched_d;
         discarded_q <= discarded_d;
      end
   end

   assign perf_fetched   = fetched_q;
   assign perf_discarded = discarded_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: random memory timing, in-order delivery model.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        clr, StallF, PCSrcD;
   logic [31:0] PCBranchD, inst_F, NPC_F;
   logic        valid_F;

   fetch_stage_if imem ();

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk       (clk),
      .clr       (clr),
      .StallF    (StallF),
      .PCSrcD    (PCSrcD),
      .PCBranchD (PCBranchD),
      .imem      (imem),
      .inst_F    (inst_F),
      .NPC_F     (NPC_F),
      .valid_F   (valid_F)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Memory model: returns the request address as the instruction word.
   bit          mem_busy;
   logic [31:0] mem_addr;
   int          mem_delay;
   bit          stale;
   int          ready_force;   // 0 random, 1 high, 2 low
   int          delay_force;   // <0 random 0..2
   // Program-order model: address of the next instruction decode should see.
   logic [31:0] exp_pc;
   int          pops;
   bit          prev_pending;
   logic [31:0] prev_addr;
   bit          accepted_evt;
   logic [31:0] accepted_addr;

   task automatic tick(input bit stall, input bit redir, input logic [31:0] tgt);
      logic req_s, rdy_s, rv_s;
      logic [31:0] addr_s;
      StallF    = stall;
      PCSrcD    = redir;
      PCBranchD = tgt;
      imem.imem_ready = 1'b0;
      if (!mem_busy) begin
         case (ready_force)
            1:       imem.imem_ready = 1'b1;
            2:       imem.imem_ready = 1'b0;
            default: imem.imem_ready = 1'($urandom_range(0, 1));
         endcase
      end
      imem.imem_rvalid = mem_busy && (mem_delay == 0);
      imem.imem_rdata  = imem.imem_rvalid ? mem_addr : $urandom();
      #1;
      if (!clr) begin
         if (!valid_F) begin
            n_tests++;
            if (inst_F !== 32'h0 || NPC_F !== 32'h0) begin
               n_fail++;
               $display("FAIL empty_head: got inst=%h npc=%h want 0/0", inst_F, NPC_F);
            end
         end else if (!stall && !redir) begin
            n_tests++;
            if (inst_F !== exp_pc || NPC_F !== exp_pc + 32'd4) begin
               n_fail++;
               $display("FAIL pop_order: got inst=%h npc=%h want inst=%h npc=%h",
                        inst_F, NPC_F, exp_pc, exp_pc + 32'd4);
            end
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         if (redir) exp_pc = tgt;
         if (mem_busy && !stale) begin
            n_tests++;
            if (imem.imem_req !== 1'b0) begin
               n_fail++;
               $display("FAIL single_outstanding: got req=%b want 0", imem.imem_req);
            end
         end
         if (prev_pending) begin
            n_tests++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== prev_addr) begin
               n_fail++;
               $display("FAIL addr_hold: got req=%b addr=%h want 1/%h",
                        imem.imem_req, imem.imem_addr, prev_addr);
            end
         end
      end else begin
         exp_pc = RST_PC;
      end
      req_s  = imem.imem_req;
      addr_s = imem.imem_addr;
      rdy_s  = imem.imem_ready;
      rv_s   = imem.imem_rvalid;
      accepted_evt = 1'b0;
      @(posedge clk);
      if (req_s && rdy_s && !clr) begin
         mem_busy      = 1'b1;
         mem_addr      = addr_s;
         mem_delay     = (delay_force < 0) ? int'($urandom_range(0, 2)) : delay_force;
         accepted_evt  = 1'b1;
         accepted_addr = addr_s;
      end else if (rv_s) begin
         mem_busy = 1'b0;
         stale    = 1'b0;
      end else if (mem_busy) begin
         mem_delay--;
      end
      prev_pending = req_s && !rdy_s && !clr;
      prev_addr    = addr_s;
      @(negedge clk);
   endtask

   task automatic test_reset();
      clr = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (imem.imem_req !== 1'b0 || imem.imem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_req: got req=%b addr=%h want 0/0", imem.imem_req, imem.imem_addr);
      end
      n_tests++;
      if (valid_F !== 1'b0 || inst_F !== 32'h0 || NPC_F !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_head: got v=%b inst=%h npc=%h want 0/0/0", valid_F, inst_F, NPC_F);
      end
      clr = 1'b0;
      ready_force = 2;
      tick(1'b0, 1'b0, 32'h0);
      n_tests++;
      if (imem.imem_req !== 1'b1 || imem.imem_addr !== RST_PC) begin
         n_fail++;
         $display("FAIL first_req: got req=%b addr=%h want 1/%h", imem.imem_req, imem.imem_addr,
                  RST_PC);
      end
   endtask

   task automatic test_sequential();
      int k = 0;
      int p0 = pops;
      ready_force = 1;
      delay_force = 0;
      repeat (12) begin
         tick(1'b0, 1'b0, 32'h0);
         if (accepted_evt) begin
            n_tests++;
            if (accepted_addr !== RST_PC + 32'(4 * k)) begin
               n_fail++;
               $display("FAIL seq_addr: got %h want %h", accepted_addr, RST_PC + 32'(4 * k));
            end
            k++;
         end
      end
      n_tests++;
      if (pops - p0 < 5 || k < 6) begin
         n_fail++;
         $display("FAIL throughput: got pops=%0d reqs=%0d want >=5/>=6", pops - p0, k);
      end
   endtask

   task automatic test_stall();
      int reqs_late = 0;
      ready_force = 1;
      delay_force = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 1'b0, 32'h0);
         if (i >= 7 && imem.imem_req) reqs_late++;
      end
      n_tests++;
      if (reqs_late != 0 || valid_F !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_idle: got late_reqs=%0d valid=%b want 0/1", reqs_late, valid_F);
      end
      ready_force = 0;
      delay_force = -1;
      repeat (20) tick(1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_redirect_wait();
      int k = 0;
      ready_force = 1;
      delay_force = 3;
      while (!mem_busy && k < 20) begin
         tick(1'b0, 1'b0, 32'h0);
         k++;
      end
      tick(1'b0, 1'b1, 32'h0000_1000);
      delay_force = 0;
      k = 0;
      while (!accepted_evt && k < 20) begin
         tick(1'b0, 1'b0, 32'h0);
         k++;
      end
      n_tests++;
      if (!accepted_evt || accepted_addr !== 32'h0000_1000) begin
         n_fail++;
         $display("FAIL redirect_wait: got accepted=%b addr=%h want 1/00001000",
                  accepted_evt, accepted_addr);
      end
      repeat (6) tick(1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_redirect_accept();
      int k = 0;
      logic [31:0] old;
      ready_force = 2;
      delay_force = 0;
      while (!(imem.imem_req && !mem_busy) && k < 20) begin
         tick(1'b0, 1'b0, 32'h0);
         k++;
      end
      old = imem.imem_addr;
      ready_force = 1;
      tick(1'b0, 1'b1, 32'h0000_1000);
      n_tests++;
      if (!accepted_evt || accepted_addr !== old) begin
         n_fail++;
         $display("FAIL redir_accept_old: got accepted=%b addr=%h want 1/%h",
                  accepted_evt, accepted_addr, old);
      end
      k = 0;
      do begin
         tick(1'b0, 1'b0, 32'h0);
         k++;
      end while (!accepted_evt && k < 20);
      n_tests++;
      if (!accepted_evt || accepted_addr !== 32'h0000_1000) begin
         n_fail++;
         $display("FAIL redir_accept_new: got accepted=%b addr=%h want 1/00001000",
                  accepted_evt, accepted_addr);
      end
      repeat (6) tick(1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_wrap();
      int k = 0;
      bit saw_zero = 1'b0;
      ready_force = 0;
      delay_force = -1;
      tick(1'b0, 1'b1, 32'hFFFF_FFF8);
      while (exp_pc !== 32'h0000_0004 && k < 60) begin
         tick(1'b0, 1'b0, 32'h0);
         if (accepted_evt && accepted_addr === 32'h0) saw_zero = 1'b1;
         k++;
      end
      n_tests++;
      if (exp_pc !== 32'h0000_0004 || !saw_zero) begin
         n_fail++;
         $display("FAIL wrap: got next_pc=%h req_at_0=%b want 00000004/1", exp_pc, saw_zero);
      end
   endtask

   task automatic test_clr();
      int k = 0;
      int bad = 0;
      ready_force = 1;
      delay_force = 3;
      while (!mem_busy && k < 20) begin
         tick(1'b0, 1'b0, 32'h0);
         k++;
      end
      clr   = 1'b1;
      stale = 1'b1;
      tick(1'b0, 1'b0, 32'h0);
      clr = 1'b0;
      delay_force = 0;
      k = 0;
      while (!accepted_evt && k < 20) begin
         if (valid_F) bad++;
         tick(1'b0, 1'b0, 32'h0);
         k++;
      end
      n_tests++;
      if (bad != 0 || !accepted_evt || accepted_addr !== RST_PC) begin
         n_fail++;
         $display("FAIL clr_stale: got valid_cycles=%0d accepted=%b addr=%h want 0/1/%h",
                  bad, accepted_evt, accepted_addr, RST_PC);
      end
      repeat (6) tick(1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_random();
      int p0 = pops;
      ready_force = 0;
      delay_force = -1;
      for (int i = 0; i < 400; i++) begin
         bit st, rd;
         st = ($urandom_range(0, 9) < 3);
         rd = ($urandom_range(0, 19) == 0);
         tick(st, rd, $urandom() & 32'hFFFF_FFFC);
      end
      n_tests++;
      if (pops - p0 < 30) begin
         n_fail++;
         $display("FAIL random_progress: got pops=%0d want >=30", pops - p0);
      end
   endtask

   initial begin
      clr = 1'b1;
      StallF = 1'b0;
      PCSrcD = 1'b0;
      PCBranchD = 32'h0;
      imem.imem_ready = 1'b0;
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata = 32'h0;
      mem_busy = 1'b0;
      mem_addr = 32'h0;
      mem_delay = 0;
      stale = 1'b0;
      ready_force = 0;
      delay_force = -1;
      exp_pc = RST_PC;
      pops = 0;
      prev_pending = 1'b0;
      prev_addr = 32'h0;
      accepted_evt = 1'b0;
      accepted_addr = 32'h0;
      @(negedge clk);
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_redirect_accept();
      test_wrap();
      test_clr();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
